ldpc_wb_responder: RTL and testbench



---
 rtl/ldpc_wb_pkg.sv | 33 +++
 rtl/ldpc_wb_fifo.sv | 82 ++++++++
 rtl/ldpc_wb_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_ldpc_wb_responder.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_wb_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_wb_pkg
// Shared definitions for the LDPC Wishbone responder: register offsets
// within the 32-byte window, CTRL/STATUS bit positions and the bus FSM
// state type.
// ---------------------------------------------------------------------------
package ldpc_wb_pkg;

  // Byte offsets inside the register window (wbs_adr_i[4:0]).
  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_GPIO   = 5'h04;
  localparam logic [4:0] OFF_TXDATA = 5'h08;
  localparam logic [4:0] OFF_RXDATA = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;

  // CTRL bit positions.
  localparam int CTRL_CORE_EN = 0;
  localparam int CTRL_GPIO_OE = 1;

  // STATUS bit positions.
  localparam int ST_TX_COUNT_LSB = 0;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_FULL      = 16;
  localparam int ST_RX_EMPTY     = 17;
  localparam int ST_OVERFLOW     = 24;
  localparam int ST_UNDERFLOW    = 25;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/ldpc_wb_fifo.sv
// ---------------------------------------------------------------------------
// ldpc_wb_fifo
// Synchronous FIFO, DEPTH entries (power of two, 2..16) of WIDTH bits.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push, din      write request / data (dropped when full, unless a pop
//                  happens in the same cycle)
//   pop            read request (ignored when empty)
//   dout           head entry, 0 while empty
//   full, empty    occupancy flags
//   count          occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ldpc_wb_fifo
  import ldpc_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [4:0]       count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (count_q == 5'd0);
  assign full    = (count_q == 5'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot a full FIFO needs for the push.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: every variable gets its default before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // validity and dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ldpc_wb_responder.sv
// ---------------------------------------------------------------------------
// ldpc_wb_responder
// Wishbone responder for the LDPC codec: CTRL, GPIO checkbits, TX FIFO
// toward the codec, RX FIFO from the codec, STATUS with sticky flags.
// Every strobe is acked exactly once, one cycle after it is sampled.
// Build option: LDPC_WB_GPIO_MIRROR_EN enables the GPIO register and the
// io_out/io_oeb drive; without it io_out = 0 and io_oeb = 16'hFFFF.
// Ports:
//   wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//   wbs_cyc/stb/we/sel/adr/dat_i  Wishbone request
//   wbs_ack_o, wbs_dat_o          Wishbone response (data 0 outside ack)
//   cw_valid_o, cw_data_o, cw_ready_i     TX stream toward the codec
//   res_valid_i, res_data_i, res_ready_o  RX stream from the codec
//   io_out, io_oeb                checkbits for mprj_io[31:16]
// ---------------------------------------------------------------------------
module ldpc_wb_responder
  import ldpc_wb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cw_valid_o,
  output logic [31:0] cw_data_o,
  input  logic        cw_ready_i,
  input  logic        res_valid_i,
  input  logic [31:0] res_data_i,
  output logic        res_ready_o,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb
);

  bus_state_e  state_q, state_d;
  logic [31:0] dat_q, dat_d;
  logic        core_en_q, core_en_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic        req, in_win;
  logic [4:0]  off;
  logic [31:0] status_word;

  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [4:0]  tx_count;
  logic [31:0] tx_head;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [4:0]  rx_count;
  logic [31:0] rx_head;

  logic        gpio_oe;
  logic [15:0] gpio_word;

`ifdef LDPC_WB_GPIO_MIRROR_EN
  logic        gpio_oe_q, gpio_oe_d;
  logic [15:0] gpio_q, gpio_d;
  assign gpio_oe   = gpio_oe_q;
  assign gpio_word = gpio_q;
  assign io_out    = gpio_q;
  assign io_oeb    = {16{~gpio_oe_q}};
`else
  assign gpio_oe   = 1'b0;
  assign gpio_word = 16'h0000;
  assign io_out    = 16'h0000;
  assign io_oeb    = 16'hFFFF;
`endif

  // Address bits [1:0] are don't-care for word registers; byte lanes and
  // data bits not mapped to any register are simply ignored.
  logic unused_ok;
  assign unused_ok = ^{wbs_adr_i[1:0], wbs_sel_i, wbs_dat_i};

  assign in_win = (wbs_adr_i[31:5] == ADDR_BASE[31:5]);
  assign off    = {wbs_adr_i[4:2], 2'b00};
  // ack is never high in IDLE, so the ~ack term is implied by the state.
  assign req    = (state_q == BUS_IDLE) & wbs_cyc_i & wbs_stb_i;

  assign wbs_ack_o   = (state_q == BUS_ACK);
  assign wbs_dat_o   = dat_q;
  assign cw_valid_o  = core_en_q & ~tx_empty;
  assign cw_data_o   = tx_head;
  assign tx_pop      = cw_valid_o & cw_ready_i;
  // A full RX can still take a result when firmware pops on the same edge.
  assign res_ready_o = ~rx_full | rx_pop;
  assign rx_push     = res_valid_i & res_ready_o;

  always_comb begin
    status_word = '0;
    status_word[ST_TX_COUNT_LSB +: 5] = tx_count;
    status_word[ST_RX_COUNT_LSB +: 5] = rx_count;
    status_word[ST_TX_FULL]   = tx_full;
    status_word[ST_RX_EMPTY]  = rx_empty;
    status_word[ST_OVERFLOW]  = ovf_q;
    status_word[ST_UNDERFLOW] = unf_q;
  end

  // Bus FSM next state plus all register side effects, which take place on
  // the IDLE -> ACK edge.
  always_comb begin
    state_d   = state_q;
    dat_d     = '0;
    core_en_d = core_en_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    tx_push   = 1'b0;
    rx_pop    = 1'b0;
`ifdef LDPC_WB_GPIO_MIRROR_EN
    gpio_oe_d = gpio_oe_q;
    gpio_d    = gpio_q;
`endif
    case (state_q)
      BUS_IDLE: begin
        if (req) begin
          state_d = BUS_ACK;
          if (in_win && wbs_we_i) begin
            case (off)
              OFF_CTRL: begin
                if (wbs_sel_i[0]) begin
                  core_en_d = wbs_dat_i[CTRL_CORE_EN];
`ifdef LDPC_WB_GPIO_MIRROR_EN
                  gpio_oe_d = wbs_dat_i[CTRL_GPIO_OE];
`endif
                end
              end
              OFF_GPIO: begin
`ifdef LDPC_WB_GPIO_MIRROR_EN
                if (wbs_sel_i[0]) gpio_d[7:0]  = wbs_dat_i[7:0];
                if (wbs_sel_i[1]) gpio_d[15:8] = wbs_dat_i[15:8];
`endif
              end
              OFF_TXDATA: begin
                tx_push = 1'b1;
                // The FIFO drops the word only when no codec pop frees a slot.
                if (tx_full && !tx_pop) ovf_d = 1'b1;
              end
              OFF_STATUS: begin
                if (wbs_dat_i[ST_OVERFLOW])  ovf_d = 1'b0;
                if (wbs_dat_i[ST_UNDERFLOW]) unf_d = 1'b0;
              end
              default: ;
            endcase
          end else if (in_win) begin
            case (off)
              OFF_CTRL: begin
                dat_d[CTRL_CORE_EN] = core_en_q;
                dat_d[CTRL_GPIO_OE] = gpio_oe;
              end
              OFF_GPIO:   dat_d[15:0] = gpio_word;
              OFF_RXDATA: begin
                if (rx_empty) begin
                  unf_d = 1'b1;
                end else begin
                  rx_pop = 1'b1;
                  dat_d  = rx_head;
                end
              end
              OFF_STATUS: dat_d = status_word;
              default: ;
            endcase
          end
        end
      end
      BUS_ACK: state_d = BUS_IDLE;
      default: state_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= BUS_IDLE;
      dat_q     <= '0;
      core_en_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
`ifdef LDPC_WB_GPIO_MIRROR_EN
      gpio_oe_q <= 1'b0;
      gpio_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dat_q     <= dat_d;
      core_en_q <= core_en_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
`ifdef LDPC_WB_GPIO_MIRROR_EN
      gpio_oe_q <= gpio_oe_d;
      gpio_q    <= gpio_d;
`endif
    end
  end

  ldpc_wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tx_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (tx_push),
    .din   (wbs_dat_i),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  ldpc_wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_rx_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (rx_push),
    .din   (res_data_i),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

endmodule

// File: tb/tb_ldpc_wb_responder.sv
// ---------------------------------------------------------------------------
// tb_ldpc_wb_responder
// Self-checking bench for ldpc_wb_responder: a register vector table,
// hand-written FIFO/reset corner sequences, and a randomized phase checked
// against a queue-based model of the FIFOs and sticky flags.
// ---------------------------------------------------------------------------
module tb_ldpc_wb_responder;
  import ldpc_wb_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h3000_0000;
`ifdef LDPC_WB_GPIO_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic        cw_valid, cw_ready, res_valid, res_ready;
  logic [31:0] cw_data, res_data;
  logic [15:0] io_out, io_oeb;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ldpc_wb_responder #(.ADDR_BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (dat_i),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (dat_o),
    .cw_valid_o  (cw_valid),
    .cw_data_o   (cw_data),
    .cw_ready_i  (cw_ready),
    .res_valid_i (res_valid),
    .res_data_i  (res_data),
    .res_ready_o (res_ready),
    .io_out      (io_out),
    .io_oeb      (io_oeb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = '0;
  endtask

  // One complete access; called at posedge+1. Returns read data and the
  // GPIO pins as seen in the ack cycle.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd,
                         output logic [15:0] io_ack, output logic [15:0] oeb_ack);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    @(posedge clk); #1;
    check("ack_high", {31'b0, ack}, 32'd1);
    rd = dat_o; io_ack = io_out; oeb_ack = io_oeb;
    idle_bus();
    @(posedge clk); #1;
    check("ack_single", {31'b0, ack}, 32'd0);
    check("dat_idle", dat_o, 32'd0);
  endtask

  task automatic wb_write(input logic [4:0] o, input logic [31:0] d);
    logic [31:0] rd;
    logic [15:0] io, oeb;
    wb_xfer(1'b1, BASE + 32'(o), d, 4'hF, rd, io, oeb);
  endtask

  task automatic wb_read(input string name, input logic [4:0] o, input logic [31:0] exp);
    logic [31:0] rd;
    logic [15:0] io, oeb;
    wb_xfer(1'b0, BASE + 32'(o), 32'd0, 4'hF, rd, io, oeb);
    check(name, rd, exp);
  endtask

  task automatic deliver(input logic [31:0] d);
    res_valid = 1'b1; res_data = d;
    @(posedge clk); #1;
    res_valid = 1'b0; res_data = '0;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    logic [15:0] exp_io;
    logic [15:0] exp_oeb;
  } vec_t;

  function automatic vec_t mk(input string n, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] r, input logic [15:0] io,
                              input logic [15:0] oeb);
    vec_t v;
    v.name = n; v.we = w; v.adr = a; v.dat = d; v.sel = s;
    v.exp_rd = r; v.exp_io = io; v.exp_oeb = oeb;
    return v;
  endfunction

  // Behavioural model state for the randomized phase.
  logic [31:0] tx_m[$];
  logic [31:0] rx_m[$];
  bit          ovf_m, unf_m;

  function automatic logic [31:0] status_model();
    return  32'(tx_m.size())
          + 32'(rx_m.size()) * 32'd256
          + ((tx_m.size() == DEPTH) ? 32'h0001_0000 : 32'd0)
          + ((rx_m.size() == 0)     ? 32'h0002_0000 : 32'd0)
          + (ovf_m ? 32'h0100_0000 : 32'd0)
          + (unf_m ? 32'h0200_0000 : 32'd0);
  endfunction

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd, exp;
    logic [15:0] io, oeb;
    logic [15:0] oe_on;

    idle_bus();
    cw_ready = 1'b0; res_valid = 1'b0; res_data = '0;

    // ---------------- reset ----------------
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_io_oeb", {16'b0, io_oeb}, 32'h0000_FFFF);
    check("rst_io_out", {16'b0, io_out}, 32'd0);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_cw_valid", {31'b0, cw_valid}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    wb_read("status_after_reset", OFF_STATUS, 32'h0002_0000);

    // ---------------- register table ----------------
    oe_on = MIR ? 16'h0000 : 16'hFFFF;
    tbl.push_back(mk("ctrl_wr_oe", 1, BASE+32'h00, 32'h2, 4'hF, 0, 16'h0000, oe_on));
    tbl.push_back(mk("ctrl_rd", 0, BASE+32'h00, 0, 4'hF, MIR ? 32'h2 : 32'h0, 16'h0000, oe_on));
    tbl.push_back(mk("gpio_ab60", 1, BASE+32'h04, 32'hAB60, 4'hF, 0, MIR ? 16'hAB60 : 16'h0, oe_on));
    tbl.push_back(mk("gpio_fff6", 1, BASE+32'h04, 32'hFFF6, 4'hF, 0, MIR ? 16'hFFF6 : 16'h0, oe_on));
    tbl.push_back(mk("gpio_byte1", 1, BASE+32'h04, 32'hFFFF_1200, 4'b0010, 0, MIR ? 16'h12F6 : 16'h0, oe_on));
    tbl.push_back(mk("gpio_rd", 0, BASE+32'h04, 0, 4'hF, MIR ? 32'h12F6 : 32'h0, MIR ? 16'h12F6 : 16'h0, oe_on));
    tbl.push_back(mk("ctrl_wr_nosel", 1, BASE+32'h00, 32'h0, 4'h0, 0, MIR ? 16'h12F6 : 16'h0, oe_on));
    tbl.push_back(mk("ctrl_rd_kept", 0, BASE+32'h00, 0, 4'hF, MIR ? 32'h2 : 32'h0, MIR ? 16'h12F6 : 16'h0, oe_on));
    tbl.push_back(mk("txdata_rd", 0, BASE+32'h08, 0, 4'hF, 0, MIR ? 16'h12F6 : 16'h0, oe_on));
    tbl.push_back(mk("rsvd_14_rd", 0, BASE+32'h14, 0, 4'hF, 0, MIR ? 16'h12F6 : 16'h0, oe_on));
    tbl.push_back(mk("rsvd_18_wr", 1, BASE+32'h18, 32'hFFFF_FFFF, 4'hF, 0, MIR ? 16'h12F6 : 16'h0, oe_on));
    tbl.push_back(mk("rsvd_1c_rd", 0, BASE+32'h1C, 0, 4'hF, 0, MIR ? 16'h12F6 : 16'h0, oe_on));
    tbl.push_back(mk("outside_rd", 0, BASE+32'h40, 0, 4'hF, 0, MIR ? 16'h12F6 : 16'h0, oe_on));
    tbl.push_back(mk("outside_gpio_wr", 1, BASE+32'h44, 32'h0, 4'hF, 0, MIR ? 16'h12F6 : 16'h0, oe_on));
    tbl.push_back(mk("gpio_rd_kept", 0, BASE+32'h04, 0, 4'hF, MIR ? 32'h12F6 : 32'h0, MIR ? 16'h12F6 : 16'h0, oe_on));
    tbl.push_back(mk("status_rd", 0, BASE+32'h10, 0, 4'hF, 32'h0002_0000, MIR ? 16'h12F6 : 16'h0, oe_on));
    for (int i = 0; i < tbl.size(); i++) begin
      wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd, io, oeb);
      check({tbl[i].name, "_rd"}, rd, tbl[i].exp_rd);
      check({tbl[i].name, "_io"}, {16'b0, io}, {16'b0, tbl[i].exp_io});
      check({tbl[i].name, "_oeb"}, {16'b0, oeb}, {16'b0, tbl[i].exp_oeb});
    end

    // ---------------- TX overflow and drain ----------------
    for (int i = 0; i < 5; i++) wb_write(OFF_TXDATA, 32'h11 + 32'(i));
    wb_read("status_tx_overflow", OFF_STATUS, 32'h0103_0004);
    check("cw_valid_gated", {31'b0, cw_valid}, 32'd0);
    wb_write(OFF_CTRL, 32'h3);
    cw_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("tx_drain_valid", {31'b0, cw_valid}, 32'd1);
      check("tx_drain_data", cw_data, 32'h11 + 32'(i));
      @(posedge clk); #1;
    end
    check("tx_drained", {31'b0, cw_valid}, 32'd0);
    cw_ready = 1'b0;
    wb_write(OFF_STATUS, 32'h0100_0000);
    wb_read("status_ovf_cleared", OFF_STATUS, 32'h0002_0000);

    // ---------------- push to cw_valid latency ----------------
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h08; dat_i = 32'h77;
    check("tx_lat_before", {31'b0, cw_valid}, 32'd0);
    @(posedge clk); #1;
    check("tx_lat_ack", {31'b0, ack}, 32'd1);
    check("tx_lat_valid", {31'b0, cw_valid}, 32'd1);
    check("tx_lat_data", cw_data, 32'h77);
    idle_bus();
    cw_ready = 1'b1;
    @(posedge clk); #1;
    cw_ready = 1'b0;
    check("tx_lat_popped", {31'b0, cw_valid}, 32'd0);

    // ---------------- push into full TX with codec pop same cycle ----------------
    for (int i = 0; i < 4; i++) wb_write(OFF_TXDATA, 32'h21 + 32'(i));
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h08; dat_i = 32'h25;
    cw_ready = 1'b1;
    @(posedge clk); #1;
    cw_ready = 1'b0;
    check("full_pop_ack", {31'b0, ack}, 32'd1);
    idle_bus();
    @(posedge clk); #1;
    wb_read("status_full_pop", OFF_STATUS, 32'h0003_0004);
    cw_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("full_pop_data", cw_data, 32'h22 + 32'(i));
      @(posedge clk); #1;
    end
    cw_ready = 1'b0;

    // ---------------- RX path, underflow, W1C ----------------
    deliver(32'hCAFE_0001);
    deliver(32'hCAFE_0002);
    wb_read("status_rx2", OFF_STATUS, 32'h0000_0200);
    wb_read("rx_first", OFF_RXDATA, 32'hCAFE_0001);
    wb_read("rx_second", OFF_RXDATA, 32'hCAFE_0002);
    wb_read("rx_empty_read", OFF_RXDATA, 32'h0);
    wb_read("status_underflow", OFF_STATUS, 32'h0202_0000);
    wb_write(OFF_TXDATA, 32'h5);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h08; dat_i = 32'h6;
    @(posedge clk); #1; idle_bus(); @(posedge clk); #1;
    for (int i = 0; i < 3; i++) wb_write(OFF_TXDATA, 32'h7);
    wb_read("status_both_sticky", OFF_STATUS, 32'h0303_0004);
    wb_write(OFF_STATUS, 32'h0300_0000);
    wb_read("status_w1c", OFF_STATUS, 32'h0003_0004);
    cw_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 cw_ready = 1'b0;

    // ---------------- RX full with firmware pop same cycle ----------------
    for (int i = 0; i < 4; i++) deliver(32'hA0 + 32'(i));
    check("rx_full_not_ready", {31'b0, res_ready}, 32'd0);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h0C;
    res_valid = 1'b1; res_data = 32'hA4;
    #1;
    check("rx_full_pop_ready", {31'b0, res_ready}, 32'd1);
    @(posedge clk); #1;
    res_valid = 1'b0;
    check("rx_full_pop_ack", {31'b0, ack}, 32'd1);
    check("rx_full_pop_data", dat_o, 32'hA0);
    idle_bus();
    @(posedge clk); #1;
    wb_read("status_rx_full", OFF_STATUS, 32'h0000_0400);
    for (int i = 1; i < 5; i++) wb_read("rx_full_order", OFF_RXDATA, 32'hA0 + 32'(i));

    // ---------------- reset during ACK ----------------
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h08; dat_i = 32'h99;
    @(posedge clk); #1;
    check("mid_ack_high", {31'b0, ack}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_ack_dropped", {31'b0, ack}, 32'd0);
    idle_bus();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_io_oeb", {16'b0, io_oeb}, 32'h0000_FFFF);
    check("mid_rst_io_out", {16'b0, io_out}, 32'd0);
    wb_read("status_after_mid_rst", OFF_STATUS, 32'h0002_0000);

    // ---------------- randomized phase against the queue model ----------------
    tx_m.delete(); rx_m.delete(); ovf_m = 0; unf_m = 0;
    wb_write(OFF_CTRL, 32'h1);
    for (int it = 0; it < 300; it++) begin
      logic [31:0] d;
      d = $urandom;
      case ($urandom_range(0, 5))
        0: begin
          wb_write(OFF_TXDATA, d);
          if (tx_m.size() < DEPTH) tx_m.push_back(d);
          else ovf_m = 1;
        end
        1: begin
          cw_ready = 1'b1;
          check("rnd_cw_valid", {31'b0, cw_valid}, {31'b0, tx_m.size() > 0});
          if (tx_m.size() > 0) check("rnd_cw_data", cw_data, tx_m[0]);
          @(posedge clk); #1;
          cw_ready = 1'b0;
          if (tx_m.size() > 0) void'(tx_m.pop_front());
        end
        2: begin
          res_valid = 1'b1; res_data = d;
          check("rnd_res_ready", {31'b0, res_ready}, {31'b0, rx_m.size() < DEPTH});
          @(posedge clk); #1;
          res_valid = 1'b0;
          if (rx_m.size() < DEPTH) rx_m.push_back(d);
        end
        3: begin
          if (rx_m.size() > 0) exp = rx_m.pop_front();
          else begin exp = 0; unf_m = 1; end
          wb_read("rnd_rxdata", OFF_RXDATA, exp);
        end
        4: begin
          exp = status_model();
          wb_read("rnd_status", OFF_STATUS, exp);
        end
        default: begin
          d = 32'($urandom_range(0, 3)) << 24;
          wb_write(OFF_STATUS, d);
          if (d[24]) ovf_m = 0;
          if (d[25]) unf_m = 0;
        end
      endcase
    end
    exp = status_model();
    wb_read("rnd_status_final", OFF_STATUS, exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
